// File: rtl/sync_bus_rx_ctrl.sv
// -----------------------------------------------------------------------------
// sync_bus_rx_ctrl
//
// Destination-side sequencer for a multi-bit clock-domain crossing using a
// toggle request / toggle acknowledge handshake. The source toggles async_req
// with async_data already stable. This block:
//   - synchronizes the request through a DEPTH-flop chain,
//   - waits a settle window,
//   - captures the quasi-static bus,
//   - presents the word with valid/ready,
//   - toggles async_ack back once the word is accepted.
//
// Optional feature macro: SYNC_BUS_RX_PARITY_EN
//   When defined, adds async_par (even parity over async_data) and a sticky
//   parity_err. A word that fails parity is dropped: it is not presented, and
//   async_ack still toggles so the source can continue.
//
// Parameters
//   WIDTH          data bus width
//   DEPTH          synchronizer stages on async_req (>= 2)
//   SETTLE_CYCLES  extra cycles between request detection and capture (>= 0)
//
// Ports
//   clk          destination clock
//   arst_n       asynchronous active-low reset
//   async_req    toggle request from the source domain (asynchronous)
//   async_data   source bus, stable from req toggle until ack toggle
//   async_par    (parity build only) even parity over async_data
//   async_ack    toggle acknowledge back to the source (registered)
//   dout         captured word
//   dout_valid   captured word available
//   dout_ready   downstream accepts dout
//   busy         controller is not idle
//   overrun_err  sticky: source toggled again before receiving ack
//   parity_err   (parity build only) sticky: captured word failed parity
//   err_clr      synchronous clear of the sticky error flags (a set wins)
//
// Timing: sync_q[0] and the dout capture input from async_data need
// false-path constraints.
// -----------------------------------------------------------------------------
module sync_bus_rx_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             async_req,
    input  logic [WIDTH-1:0] async_data,
`ifdef SYNC_BUS_RX_PARITY_EN
    input  logic             async_par,
    output logic             parity_err,
`endif
    output logic             async_ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun_err,
    input  logic             err_clr
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    // The cycle that detects the request is itself the first settle cycle.
    // For this reason the counter is loaded with SETTLE_CYCLES-1. With no
    // settle window at all, the capture happens straight from IDLE. This
    // places dout_valid on edge DEPTH+SETTLE_CYCLES+1 after the request
    // is first sampled.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

`ifdef SYNC_BUS_RX_PARITY_EN
    function automatic logic parity_mismatch(input logic [WIDTH-1:0] data, input logic par);
        return (^data) != par;
    endfunction
`endif

    logic [DEPTH-1:0] sync_q;
    logic             req_s;
    logic             req_seen_q;
    logic             req_edge;

    state_t           state_q,  state_nx;
    logic [CNT_W-1:0] cnt_q,    cnt_nx;
    logic [WIDTH-1:0] dout_q,   dout_nx;
    logic             valid_q,  valid_nx;
    logic             ack_q,    ack_nx;
    logic             ovr_q,    ovr_nx;
    logic             busy_q;
    logic             capture;
    logic             par_bad;
`ifdef SYNC_BUS_RX_PARITY_EN
    logic             par_q,    par_nx;
`endif

    assign req_s    = sync_q[DEPTH-1];
    // req_seen follows req_s every cycle. A toggle that arrives while a
    // transfer is in flight is therefore consumed here. It never starts a
    // second transfer.
    assign req_edge = req_s ^ req_seen_q;

`ifdef SYNC_BUS_RX_PARITY_EN
    assign par_bad  = parity_mismatch(async_data, async_par);
`else
    assign par_bad  = 1'b0;
`endif

    // ---- request synchronizer ----
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q     <= '0;
            req_seen_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[DEPTH-2:0], async_req};
            req_seen_q <= req_s;
        end
    end

    // ---- next-state / next-output logic ----
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        dout_nx  = dout_q;
        valid_nx = valid_q;
        ack_nx   = ack_q;
        ovr_nx   = ovr_q;
        capture  = 1'b0;
`ifdef SYNC_BUS_RX_PARITY_EN
        par_nx   = par_q;
`endif

        // Clear first. Any set below in the same cycle overrides the clear.
        if (err_clr) begin
            ovr_nx = 1'b0;
`ifdef SYNC_BUS_RX_PARITY_EN
            par_nx = 1'b0;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (req_edge) begin
                    if (SETTLE_CYCLES == 0) begin
                        capture = 1'b1;
                    end else begin
                        state_nx = ST_SETTLE;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (req_edge) ovr_nx = 1'b1;
                if (cnt_q != '0) cnt_nx  = cnt_q - CNT_W'(1);
                else             capture = 1'b1;
            end
            ST_PRESENT: begin
                if (req_edge) ovr_nx = 1'b1;
                if (valid_q && dout_ready) begin
                    valid_nx = 1'b0;
                    ack_nx   = ~ack_q;
                    state_nx = ST_IDLE;
                end
            end
            ST_DROP: begin
                // The word was discarded. Acknowledge it anyway so the
                // source is released.
                if (req_edge) ovr_nx = 1'b1;
                ack_nx   = ~ack_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        if (capture) begin
            if (par_bad) begin
`ifdef SYNC_BUS_RX_PARITY_EN
                par_nx   = 1'b1;
`endif
                state_nx = ST_DROP;
            end else begin
                dout_nx  = async_data;
                valid_nx = 1'b1;
                state_nx = ST_PRESENT;
            end
        end
    end

    // ---- state and output registers ----
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SYNC_BUS_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            dout_q  <= dout_nx;
            valid_q <= valid_nx;
            ack_q   <= ack_nx;
            ovr_q   <= ovr_nx;
            busy_q  <= (state_nx != ST_IDLE);
`ifdef SYNC_BUS_RX_PARITY_EN
            par_q   <= par_nx;
`endif
        end
    end

    assign async_ack   = ack_q;
    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign busy        = busy_q;
    assign overrun_err = ovr_q;
`ifdef SYNC_BUS_RX_PARITY_EN
    assign parity_err  = par_q;
`endif

endmodule

// File: tb/tb_sync_bus_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_bus_rx_ctrl
//
// Testbench for two instances of sync_bus_rx_ctrl:
//   - dut1: DEPTH=2, SETTLE_CYCLES=2.
//   - dut2: DEPTH=3, SETTLE_CYCLES=0.
// A source-side model toggles the request and keeps an expected-word queue
// and an expected ack level. Latency is computed as DEPTH+SETTLE_CYCLES+1.
// -----------------------------------------------------------------------------
module tb_sync_bus_rx_ctrl;

    localparam int D1 = 2, K1 = 2, LAT1 = D1 + K1 + 1;
    localparam int D2 = 3, K2 = 0, LAT2 = D2 + K2 + 1;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        err_clr;

    logic        req1, ready1, ack1, valid1, busy1, ovr1;
    logic [31:0] data1, dout1;
    logic        req2, ready2, ack2, valid2, busy2, ovr2;
    logic [31:0] data2, dout2;
`ifdef SYNC_BUS_RX_PARITY_EN
    logic        par1, par2, perr1, perr2;
    assign par1 = ^data1;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        exp_ack1 = 1'b0;
    logic        exp_ack2 = 1'b0;

    always #5 clk = ~clk;

    sync_bus_rx_ctrl #(.WIDTH(32), .DEPTH(D1), .SETTLE_CYCLES(K1)) dut1 (
        .clk(clk), .arst_n(arst_n), .async_req(req1), .async_data(data1),
`ifdef SYNC_BUS_RX_PARITY_EN
        .async_par(par1), .parity_err(perr1),
`endif
        .async_ack(ack1), .dout(dout1), .dout_valid(valid1), .dout_ready(ready1),
        .busy(busy1), .overrun_err(ovr1), .err_clr(err_clr)
    );

    sync_bus_rx_ctrl #(.WIDTH(32), .DEPTH(D2), .SETTLE_CYCLES(K2)) dut2 (
        .clk(clk), .arst_n(arst_n), .async_req(req2), .async_data(data2),
`ifdef SYNC_BUS_RX_PARITY_EN
        .async_par(par2), .parity_err(perr2),
`endif
        .async_ack(ack2), .dout(dout2), .dout_valid(valid2), .dout_ready(ready2),
        .busy(busy2), .overrun_err(ovr2), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for dout_valid on dut1. Returns the edge number, or 0 on timeout.
    task automatic wait_valid1(output int lat);
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (valid1) begin
                lat = e;
                break;
            end
        end
    endtask

    // The request was already issued (the word is at the head of exp_q).
    // This task checks presentation, backpressure and the ack.
    task automatic await_word(input int hold);
        int          lat;
        logic [31:0] w;
        w = exp_q.pop_front();
        ready1 = (hold == 0);
        wait_valid1(lat);
        check("latency", 64'(lat), 64'(LAT1));
        check("dout", 64'(dout1), 64'(w));
        check("busy_present", 64'(busy1), 64'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_valid", 64'(valid1), 64'd1);
            check("bp_dout", 64'(dout1), 64'(w));
            check("bp_ack", 64'(ack1), 64'(exp_ack1));
        end
        ready1 = 1'b1;
        tick();
        exp_ack1 = ~exp_ack1;
        check("ack_toggle", 64'(ack1), 64'(exp_ack1));
        check("valid_drop", 64'(valid1), 64'd0);
        check("busy_idle", 64'(busy1), 64'd0);
        ready1 = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] d, input int hold);
        data1 = d;
        req1  = ~req1;
        exp_q.push_back(d);
        await_word(hold);
    endtask

    task automatic xfer2(input logic [31:0] d, input logic bad);
        int          lat;
        logic [31:0] w;
        lat    = 0;
        w      = '0;
        data2  = d;
`ifdef SYNC_BUS_RX_PARITY_EN
        par2   = (^d) ^ bad;
`endif
        ready2 = 1'b1;
        req2   = ~req2;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (valid2 && lat == 0) begin
                lat = e;
                w   = dout2;
            end
        end
        exp_ack2 = ~exp_ack2;
        if (bad) begin
            check("d2_no_valid", 64'(lat), 64'd0);
`ifdef SYNC_BUS_RX_PARITY_EN
            check("d2_parity_err", 64'(perr2), 64'd1);
`endif
        end else begin
            check("d2_latency", 64'(lat), 64'(LAT2));
            check("d2_dout", 64'(w), 64'(d));
        end
        check("d2_ack", 64'(ack2), 64'(exp_ack2));
        check("d2_busy", 64'(busy2), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        arst_n  = 1'b0;
        err_clr = 1'b0;
        req1 = 1'b0; data1 = '0; ready1 = 1'b0;
        req2 = 1'b0; data2 = '0; ready2 = 1'b0;
`ifdef SYNC_BUS_RX_PARITY_EN
        par2 = 1'b0;
`endif
        #1;
        check("rst_dout", 64'(dout1), 64'd0);
        check("rst_valid", 64'(valid1), 64'd0);
        check("rst_ack", 64'(ack1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_ovr", 64'(ovr1), 64'd0);
        check("rst_ack2", 64'(ack2), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        tick();

        // Basic transfer, then backpressure.
        xfer(32'hDEADBEEF, 0);
        xfer(32'h12345678, 10);

        // Back-to-back transfers.
        for (int i = 1; i <= 4; i++) xfer(32'(i), 0);
        check("b2b_ovr", 64'(ovr1), 64'd0);

        // Randomized words, backpressure and gaps.
        for (int i = 0; i < 12; i++) begin
            xfer($urandom, int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 3)) tick();
        end
        check("rand_ovr", 64'(ovr1), 64'd0);

        // Overrun: second toggle while the word is being presented.
        begin
            int lat;
            ready1 = 1'b0;
            data1  = 32'hA5A50001;
            req1   = ~req1;
            wait_valid1(lat);
            check("ovr_latency", 64'(lat), 64'(LAT1));
            req1 = ~req1;
            repeat (D1 + 2) begin
                tick();
                check("ovr_hold_valid", 64'(valid1), 64'd1);
            end
            check("ovr_set", 64'(ovr1), 64'd1);
            check("ovr_dout", 64'(dout1), 64'hA5A50001);
            ready1 = 1'b1;
            tick();
            ready1 = 1'b0;
            exp_ack1 = ~exp_ack1;
            check("ovr_ack", 64'(ack1), 64'(exp_ack1));
            seen = 0;
            repeat (10) begin
                tick();
                if (valid1) seen++;
            end
            check("ovr_no_extra_word", 64'(seen), 64'd0);
            check("ovr_single_ack", 64'(ack1), 64'(exp_ack1));
            check("ovr_sticky", 64'(ovr1), 64'd1);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check("ovr_clear", 64'(ovr1), 64'd0);
        end
        xfer(32'h0000BEEF, 1);

        // Second instance: zero settle window, three sync stages.
        xfer2(32'hCAFE0001, 1'b0);
`ifdef SYNC_BUS_RX_PARITY_EN
        xfer2(32'h0BAD0002, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("d2_parity_clear", 64'(perr2), 64'd0);
`endif
        xfer2(32'h00000077, 1'b0);

        // Reset in the middle of SETTLE, with the request left at 1.
        if (req1) xfer(32'h55AA55AA, 0);
        data1  = 32'h0F0F0F0F;
        req1   = 1'b1;
        ready1 = 1'b0;
        repeat (D1 + 1) tick();
        check("mid_busy", 64'(busy1), 64'd1);
        tick();
        arst_n = 1'b0;
        #1;
        check("mid_rst_dout", 64'(dout1), 64'd0);
        check("mid_rst_valid", 64'(valid1), 64'd0);
        check("mid_rst_ack", 64'(ack1), 64'd0);
        check("mid_rst_busy", 64'(busy1), 64'd0);
        check("mid_rst_ack2", 64'(ack2), 64'd0);
        exp_ack1 = 1'b0;
        exp_ack2 = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        exp_q.push_back(32'h0F0F0F0F);
        await_word(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
